// File: rtl/zx_bus_pkg.sv
// Shared types and constants for the Z80 bus-master engine.
package zx_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RELEASE,
    ST_NMI,
    ST_DONE
  } zx_state_e;

  // Bit positions inside ctrl_bus = {mreq_n, iorq_n, rd_n, wr_n}
  localparam int unsigned CTRL_MREQ = 3;
  localparam int unsigned CTRL_IORQ = 2;
  localparam int unsigned CTRL_RD   = 1;
  localparam int unsigned CTRL_WR   = 0;

  localparam logic DIR_WR    = 1'b1;
  localparam logic DIR_RD    = 1'b0;
  localparam logic SPACE_MEM = 1'b0;
  localparam logic SPACE_IO  = 1'b1;

endpackage

// File: rtl/zx_sync_fifo.sv
// Synchronous FIFO with flush; rd_data shows the head entry combinationally.
module zx_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage array, written on an accepted push
  always_ff @(posedge clk) begin
    if (push && !full && !flush) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Pointer update; flush empties the FIFO and drops a coincident push
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/zx_bus_master.sv
// Z80 bus-master block transfer engine (BUSREQ/BUSACK handshake, mem or I/O,
// read or write). Optional macro ZXBM_NMI_EN: pulse nmi_n low for 8 cycles
// after the bus is released, before done.
module zx_bus_master
  import zx_bus_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned STROBE_CYC = 3
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              start,
  input  logic              dir,
  input  logic              space,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              bus_req_n,
  input  logic              bus_ack_n,
  output logic [ADDR_W-1:0] address,
  output logic [7:0]        data_out,
  input  logic [7:0]        data_in,
  output logic              data_oe,
  output logic [3:0]        ctrl_bus,
  output logic              nmi_n
);
  localparam int unsigned SW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
  localparam logic [SW-1:0]   STB_LAST = SW'(STROBE_CYC - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  zx_state_e         state, state_nxt;
  logic              ack_s1, ack_s2;
  logic              dir_q, space_q, abort_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   cnt_q;
  logic [SW-1:0]     strb_cnt;
  logic [7:0]        data_out_q, out_data_q;
  logic              oe_q, out_valid_q;
  logic              fifo_empty, fifo_full, fifo_pop;
  logic [7:0]        fifo_rd_data;
  logic              abort_any, setup_go, strb_last, in_bus, capture;
`ifdef ZXBM_NMI_EN
  logic [2:0]        nmi_cnt;
`endif

  assign abort_any = abort || abort_q;
  assign in_bus    = (state == ST_REQ) || (state == ST_SETUP) ||
                     (state == ST_STROBE) || (state == ST_HOLD);
  assign setup_go  = (dir_q == DIR_WR) ? !fifo_empty : !out_valid_q;
  assign strb_last = (strb_cnt == STB_LAST);
  assign fifo_pop  = (state == ST_SETUP) && !abort_any && (dir_q == DIR_WR) && !fifo_empty;
  assign capture   = (state == ST_STROBE) && strb_last && (dir_q == DIR_RD);

  zx_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .push    (in_valid),
    .pop     (fifo_pop),
    .flush   (state == ST_DONE),
    .wr_data (in_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Two-flop synchroniser for the asynchronous BUSACK pin
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      ack_s1 <= 1'b1;
      ack_s2 <= 1'b1;
    end else begin
      ack_s1 <= bus_ack_n;
      ack_s2 <= ack_s1;
    end
  end

  // State register
  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = (length == '0) ? ST_DONE : ST_REQ;
      ST_REQ:     if (abort_any) state_nxt = ST_RELEASE;
                  else if (!ack_s2) state_nxt = ST_SETUP;
      ST_SETUP:   if (abort_any) state_nxt = ST_RELEASE;
                  else if (setup_go) state_nxt = ST_STROBE;
      ST_STROBE:  if (strb_last) state_nxt = ST_HOLD;
      ST_HOLD:    state_nxt = ((cnt_q == CNT_ONE) || abort_any) ? ST_RELEASE : ST_SETUP;
`ifdef ZXBM_NMI_EN
      ST_RELEASE: if (ack_s2) state_nxt = ST_NMI;
      ST_NMI:     if (nmi_cnt == 3'd7) state_nxt = ST_DONE;
`else
      ST_RELEASE: if (ack_s2) state_nxt = ST_DONE;
`endif
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Transfer datapath: latched parameters, counters, bus data and read slot
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      dir_q       <= DIR_RD;
      space_q     <= SPACE_MEM;
      abort_q     <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      strb_cnt    <= '0;
      data_out_q  <= '0;
      oe_q        <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (state == ST_IDLE) begin
        abort_q <= 1'b0;
        if (start && (length != '0)) begin
          dir_q   <= dir;
          space_q <= space;
          addr_q  <= base_addr;
          cnt_q   <= length;
        end
      end else if (in_bus && abort) begin
        abort_q <= 1'b1;
      end
      if (state == ST_SETUP) strb_cnt <= '0;
      if (state == ST_STROBE) strb_cnt <= strb_cnt + SW'(1);
      if (fifo_pop) begin
        data_out_q <= fifo_rd_data;
        oe_q       <= 1'b1;
      end
      if (state == ST_HOLD) begin
        cnt_q  <= cnt_q - CNT_ONE;
        addr_q <= addr_q + ADDR_W'(1);
      end
      if (state == ST_RELEASE) oe_q <= 1'b0;
      if (capture) begin
        out_data_q  <= data_in;
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef ZXBM_NMI_EN
  // NMI low-phase length counter
  always_ff @(posedge clk_clk) begin
    if (reset_reset || (state != ST_NMI)) nmi_cnt <= '0;
    else                                  nmi_cnt <= nmi_cnt + 3'd1;
  end
`endif

  // Outputs decoded from state plus held datapath registers
  always_comb begin
    ctrl_bus = '1;
    if (state == ST_STROBE) begin
      ctrl_bus[(space_q == SPACE_IO) ? CTRL_IORQ : CTRL_MREQ] = 1'b0;
      ctrl_bus[(dir_q == DIR_WR) ? CTRL_WR : CTRL_RD]         = 1'b0;
    end
    bus_req_n = !in_bus;
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    aborted   = (state == ST_DONE) && abort_q;
`ifdef ZXBM_NMI_EN
    nmi_n     = (state != ST_NMI);
`else
    nmi_n     = 1'b1;
`endif
  end

  assign in_ready  = !fifo_full;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign address   = addr_q;
  assign data_out  = data_out_q;
  assign data_oe   = oe_q;

endmodule

// File: tb/tb_zx_bus_master.sv
// Self-checking bench for zx_bus_master with a Z80 bus responder and a
// transaction-level model of the expected strobe sequence.
module tb_zx_bus_master;
  import zx_bus_pkg::*;

  localparam int SC = 3;
`ifdef ZXBM_NMI_EN
  localparam int NMI_EXP = 8;
`else
  localparam int NMI_EXP = 0;
`endif

  typedef logic [7:0] bq_t [$];
  typedef struct {
    bit wr; bit rd; bit mem; bit io; bit oe; bit stable;
    logic [15:0] a; logic [7:0] d; int len; int t0;
  } rec_t;

  logic        clk = 1'b0, reset_reset = 1'b1;
  logic        start = 1'b0, dir = 1'b0, space = 1'b0, abort = 1'b0;
  logic [15:0] base_addr = '0;
  logic [16:0] length = '0;
  logic        busy, done, aborted;
  logic        in_valid = 1'b0, in_ready;
  logic [7:0]  in_data = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        bus_req_n, bus_ack_n = 1'b1;
  logic [15:0] address;
  logic [7:0]  data_out, data_in;
  logic        data_oe;
  logic [3:0]  ctrl_bus;
  logic        nmi_n;

  int checks = 0, errors = 0;
  rec_t recs[$], exp_q[$], cur;
  logic [7:0] outq[$];
  bit in_stb, req_seen, ready_hold, ready_rand, hold_after_first;
  int nstb, cyc, nmi_low, ndone, ack_dly, ack_cnt;
  logic [7:0] io_val;
  logic [7:0] zmem [65536];

  always #5 clk = ~clk;

  zx_bus_master #(.ADDR_W(16), .FIFO_DEPTH(16), .STROBE_CYC(SC)) dut (
    .clk_clk(clk), .reset_reset(reset_reset), .start(start), .dir(dir), .space(space),
    .base_addr(base_addr), .length(length), .abort(abort), .busy(busy), .done(done),
    .aborted(aborted), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .bus_req_n(bus_req_n), .bus_ack_n(bus_ack_n), .address(address),
    .data_out(data_out), .data_in(data_in), .data_oe(data_oe),
    .ctrl_bus(ctrl_bus), .nmi_n(nmi_n)
  );

  // Z80 side: I/O reads return io_val, memory reads come from zmem
  assign data_in = (ctrl_bus[CTRL_IORQ] == 1'b0) ? io_val : zmem[address];

  // Z80 grants the bus ack_dly cycles after BUSREQ, drops BUSACK on release
  always @(negedge clk) begin
    if (bus_req_n == 1'b0) begin
      if (ack_cnt >= ack_dly) bus_ack_n = 1'b0;
      else ack_cnt++;
    end else begin
      bus_ack_n = 1'b1;
      ack_cnt = 0;
    end
    out_ready = ready_hold ? 1'b0 : (ready_rand ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // Bus monitor: one record per strobe, plus handshake / done / stream log
  always @(posedge clk) begin
    cyc++;
    if (reset_reset) begin
      in_stb = 0;
    end else begin
      if (ctrl_bus[CTRL_RD] == 1'b0 || ctrl_bus[CTRL_WR] == 1'b0) begin
        if (!in_stb) begin
          in_stb = 1; nstb++;
          cur.t0 = cyc; cur.len = 0; cur.a = address; cur.stable = 1;
          cur.wr = !ctrl_bus[CTRL_WR]; cur.rd = !ctrl_bus[CTRL_RD];
          cur.mem = !ctrl_bus[CTRL_MREQ]; cur.io = !ctrl_bus[CTRL_IORQ]; cur.oe = data_oe;
        end
        cur.len++;
        cur.d = cur.wr ? data_out : data_in;
        if (address !== cur.a || data_oe !== cur.oe) cur.stable = 0;
      end else if (in_stb) begin
        in_stb = 0;
        recs.push_back(cur);
      end
      if (bus_req_n == 1'b0) req_seen = 1;
      if (nmi_n == 1'b0) nmi_low++;
      if (done === 1'b1) ndone++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        outq.push_back(out_data);
        if (hold_after_first) begin ready_hold = 1; hold_after_first = 0; end
      end
    end
  end

  // Reference: byte i of a transfer touches (base+i) mod 64K for STROBE_CYC cycles
  function automatic void model(input logic d, input logic sp, input logic [15:0] b,
                                input int n, input bq_t wq);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      rec_t r;
      r.a = 16'((32'(b) + i) % 65536);
      r.wr = d; r.rd = !d; r.mem = !sp; r.io = sp; r.oe = d; r.stable = 1;
      r.d = d ? wq[i] : (sp ? io_val : zmem[r.a]);
      r.len = SC; r.t0 = 0;
      exp_q.push_back(r);
    end
  endfunction

  function automatic bit rec_eq(input rec_t x, input rec_t y);
    return x.wr == y.wr && x.rd == y.rd && x.mem == y.mem && x.io == y.io &&
           x.oe == y.oe && x.stable && x.a === y.a && x.d === y.d && x.len == y.len;
  endfunction

  function automatic string rec_str(input rec_t r);
    return $sformatf("a=%h d=%h wr=%0d rd=%0d mreq=%0d iorq=%0d oe=%0d stable=%0d len=%0d",
                     r.a, r.d, r.wr, r.rd, r.mem, r.io, r.oe, r.stable, r.len);
  endfunction

  task automatic clear_log();
    recs.delete(); outq.delete();
    nstb = 0; req_seen = 0; nmi_low = 0; ndone = 0;
  endtask

  task automatic push_bytes(input bq_t q);
    @(negedge clk);
    foreach (q[i]) begin
      in_valid = 1'b1; in_data = q[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic start_xfer(input logic d, input logic sp, input logic [15:0] b,
                            input logic [16:0] n, input bit with_abort);
    @(negedge clk);
    dir = d; space = sp; base_addr = b; length = n; start = 1'b1; abort = with_abort;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    if ({bus_req_n, ctrl_bus, data_oe, address, data_out, busy, done, aborted, out_valid, nmi_n, in_ready}
        !== {1'b1, 4'hF, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset_values: req_n=%b ctrl=%h oe=%b addr=%h dout=%h busy=%b done=%b abt=%b ov=%b nmi=%b ir=%b",
               bus_req_n, ctrl_bus, data_oe, address, data_out, busy, done, aborted, out_valid, nmi_n, in_ready);
    end
    checks++;
  endtask

  task automatic test_write4();
    bq_t wq = '{8'h11, 8'h22, 8'h33, 8'h44};
    bit abt;
    clear_log(); ack_dly = 3;
    push_bytes(wq);
    model(DIR_WR, SPACE_MEM, 16'h4000, 4, wq);
    start_xfer(DIR_WR, SPACE_MEM, 16'h4000, 17'd4, 0);
    repeat (6) @(negedge clk);
    start = 1'b1; length = '0; dir = DIR_RD;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2000 && done !== 1'b1; i++) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL write4_done: timeout, done=%b want 1", done); end
    abt = aborted;
    repeat (3) @(negedge clk);
    checks++;
    if (recs.size() != 4) begin errors++; $display("FAIL write4_count: got %0d strobes want 4", recs.size()); end
    for (int i = 0; i < recs.size() && i < 4; i++) begin
      checks++;
      if (!rec_eq(recs[i], exp_q[i])) begin
        errors++; $display("FAIL write4_strobe%0d: got %s want %s", i, rec_str(recs[i]), rec_str(exp_q[i]));
      end
      if (i > 0) begin
        checks++;
        if (recs[i].t0 - recs[i-1].t0 != SC + 2) begin
          errors++; $display("FAIL write4_rate%0d: got %0d cycles want %0d", i, recs[i].t0 - recs[i-1].t0, SC + 2);
        end
      end
    end
    checks++;
    if (abt !== 1'b0 || ndone != 1 || bus_req_n !== 1'b1 || nmi_low != NMI_EXP) begin
      errors++; $display("FAIL write4_end: aborted=%b dones=%0d req_n=%b nmi_low=%0d want 0/1/1/%0d",
                         abt, ndone, bus_req_n, nmi_low, NMI_EXP);
    end
  endtask

  task automatic test_read_io();
    bq_t none;
    clear_log(); ack_dly = 1; io_val = 8'hA5;
    model(DIR_RD, SPACE_IO, 16'h00FE, 3, none);
    hold_after_first = 1; ready_hold = 0;
    start_xfer(DIR_RD, SPACE_IO, 16'h00FE, 17'd3, 0);
    repeat (40) @(negedge clk);
    checks++;
    if (nstb != 2 || outq.size() != 1 || bus_req_n !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL read_stall: strobes=%0d delivered=%0d req_n=%b out_valid=%b want 2/1/0/1",
                         nstb, outq.size(), bus_req_n, out_valid);
    end
    ready_hold = 0;
    for (int i = 0; i < 2000 && done !== 1'b1; i++) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL read_done: timeout, done=%b want 1", done); end
    repeat (4) @(negedge clk);
    checks++;
    if (recs.size() != 3) begin errors++; $display("FAIL read_count: got %0d strobes want 3", recs.size()); end
    for (int i = 0; i < recs.size() && i < 3; i++) begin
      checks++;
      if (!rec_eq(recs[i], exp_q[i])) begin
        errors++; $display("FAIL read_strobe%0d: got %s want %s", i, rec_str(recs[i]), rec_str(exp_q[i]));
      end
    end
    checks++;
    if (outq.size() != 3 || outq[0] !== 8'hA5 || outq[1] !== 8'hA5 || outq[2] !== 8'hA5) begin
      errors++; $display("FAIL read_stream: got %0d bytes %p want 3 x a5", outq.size(), outq);
    end
  endtask

  task automatic test_wrap();
    bq_t wq;
    clear_log(); ack_dly = 0;
    wq.push_back(8'($urandom)); wq.push_back(8'($urandom));
    push_bytes(wq);
    model(DIR_WR, SPACE_MEM, 16'hFFFF, 2, wq);
    start_xfer(DIR_WR, SPACE_MEM, 16'hFFFF, 17'd2, 1);
    for (int i = 0; i < 2000 && done !== 1'b1; i++) @(negedge clk);
    checks++;
    if (done !== 1'b1 || aborted !== 1'b0) begin
      errors++; $display("FAIL wrap_done: done=%b aborted=%b want 1/0", done, aborted);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (recs.size() != 2) begin errors++; $display("FAIL wrap_count: got %0d strobes want 2", recs.size()); end
    for (int i = 0; i < recs.size() && i < 2; i++) begin
      checks++;
      if (!rec_eq(recs[i], exp_q[i])) begin
        errors++; $display("FAIL wrap_strobe%0d: got %s want %s", i, rec_str(recs[i]), rec_str(exp_q[i]));
      end
    end
  endtask

  task automatic test_zero_len();
    clear_log();
    start_xfer(DIR_WR, SPACE_MEM, 16'h1234, 17'd0, 0);
    checks++;
    if (done !== 1'b1 || aborted !== 1'b0) begin
      errors++; $display("FAIL zero_len_done: done=%b aborted=%b want 1/0", done, aborted);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (req_seen || ndone != 1 || nstb != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_len_bus: req_seen=%0d dones=%0d strobes=%0d busy=%b want 0/1/0/0",
                         req_seen, ndone, nstb, busy);
    end
  endtask

  task automatic test_abort();
    bq_t wq, one;
    bit abt;
    clear_log(); ack_dly = 2;
    for (int i = 0; i < 10; i++) wq.push_back(8'($urandom));
    push_bytes(wq);
    model(DIR_WR, SPACE_MEM, 16'h8000, 10, wq);
    start_xfer(DIR_WR, SPACE_MEM, 16'h8000, 17'd10, 0);
    for (int i = 0; i < 2000 && nstb < 2; i++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int i = 0; i < 2000 && done !== 1'b1; i++) @(negedge clk);
    abt = aborted;
    checks++;
    if (done !== 1'b1 || abt !== 1'b1) begin
      errors++; $display("FAIL abort_done: done=%b aborted=%b want 1/1", done, abt);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (recs.size() != 2 || !rec_eq(recs[0], exp_q[0]) || !rec_eq(recs[1], exp_q[1])) begin
      errors++; $display("FAIL abort_strobes: got %0d strobes want 2 matching model", recs.size());
    end
    clear_log();
    one.push_back(8'h77);
    push_bytes(one);
    start_xfer(DIR_WR, SPACE_MEM, 16'h9000, 17'd1, 0);
    for (int i = 0; i < 2000 && done !== 1'b1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (recs.size() != 1 || recs[0].d !== 8'h77 || recs[0].a !== 16'h9000) begin
      errors++; $display("FAIL abort_flush: got %0d strobes first d=%h want 1 strobe d=77",
                         recs.size(), (recs.size() > 0) ? recs[0].d : 8'hxx);
    end
  endtask

  task automatic test_reset_mid();
    bq_t wq = '{8'h01, 8'h02, 8'h03};
    clear_log(); ack_dly = 0;
    push_bytes(wq);
    start_xfer(DIR_WR, SPACE_MEM, 16'h2000, 17'd3, 0);
    for (int i = 0; i < 2000 && nstb < 1; i++) @(negedge clk);
    checks++;
    if (ctrl_bus[CTRL_WR] !== 1'b0) begin
      errors++; $display("FAIL reset_mid_pre: wr_n=%b want 0", ctrl_bus[CTRL_WR]);
    end
    reset_reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus_req_n !== 1'b1 || ctrl_bus !== 4'hF || data_oe !== 1'b0 || busy !== 1'b0 || address !== 16'h0) begin
      errors++; $display("FAIL reset_mid: req_n=%b ctrl=%h oe=%b busy=%b addr=%h want 1/f/0/0/0000",
                         bus_req_n, ctrl_bus, data_oe, busy, address);
    end
    @(negedge clk);
    reset_reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      bq_t wq;
      logic d, sp;
      logic [15:0] b;
      int n;
      clear_log();
      d = 1'($urandom); sp = 1'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      n = $urandom_range(1, 6);
      ack_dly = $urandom_range(0, 4);
      io_val = 8'($urandom);
      if (d) begin
        for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
        push_bytes(wq);
      end
      model(d, sp, b, n, wq);
      ready_rand = 1;
      start_xfer(d, sp, b, 17'(n), 0);
      for (int i = 0; i < 2000 && done !== 1'b1; i++) @(negedge clk);
      checks++;
      if (done !== 1'b1 || aborted !== 1'b0) begin
        errors++; $display("FAIL rand%0d_done: done=%b aborted=%b want 1/0", k, done, aborted);
      end
      ready_rand = 0;
      repeat (5) @(negedge clk);
      checks++;
      if (recs.size() != n || nmi_low != NMI_EXP) begin
        errors++; $display("FAIL rand%0d_count: got %0d strobes nmi_low=%0d want %0d/%0d",
                           k, recs.size(), nmi_low, n, NMI_EXP);
      end
      for (int i = 0; i < recs.size() && i < n; i++) begin
        checks++;
        if (!rec_eq(recs[i], exp_q[i])) begin
          errors++; $display("FAIL rand%0d_strobe%0d: got %s want %s", k, i, rec_str(recs[i]), rec_str(exp_q[i]));
        end
      end
      if (!d) begin
        checks++;
        if (outq.size() != n) begin
          errors++; $display("FAIL rand%0d_stream_len: got %0d want %0d", k, outq.size(), n);
        end
        for (int i = 0; i < outq.size() && i < n; i++) begin
          checks++;
          if (outq[i] !== exp_q[i].d) begin
            errors++; $display("FAIL rand%0d_stream%0d: got %h want %h", k, i, outq[i], exp_q[i].d);
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) zmem[i] = 8'($urandom);
    io_val = 8'h00; ack_dly = 0; ack_cnt = 0;
    repeat (3) @(negedge clk);
    reset_reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_write4();
    test_read_io();
    test_wrap();
    test_zero_len();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
